// File: rtl/gearbox_64_40_if.sv
// Handshake bundle between the upstream 64-bit source, the 64->40 gearbox and the 40-bit SerDes side.
interface gearbox_64_40_if;
  logic        in_enable;
  logic [63:0] in_data;
  logic        in_datavalid;
  logic        out_idle;
  logic [39:0] out_data;
  logic        out_datavalid;
  logic        in_idle;
  logic        empty_save;

  modport master (
    output in_enable, in_data, in_datavalid, in_idle,
    input  out_idle, out_data, out_datavalid, empty_save
  );

  modport slave (
    input  in_enable, in_data, in_datavalid, in_idle,
    output out_idle, out_data, out_datavalid, empty_save
  );
endinterface

// File: rtl/gearbox_64_40.sv
// 64-bit to 40-bit byte gearbox over a 16-byte buffer; slot 0 (bits 7:0) is the oldest byte.
// Optional status outputs fill_level/overflow are built when GEARBOX_64_40_STATUS_EN is defined.
module gearbox_64_40 (
  input  logic           clk,
  input  logic           reset_n,
  gearbox_64_40_if.slave bus
`ifdef GEARBOX_64_40_STATUS_EN
  ,
  output logic [4:0]     fill_level,
  output logic           overflow
`endif
);

  logic [127:0] data_p0;
  logic [4:0]   fill_p0;
  logic [127:0] data_nxt;
  logic [127:0] shifted;
  logic [4:0]   fill_nxt;
  logic [4:0]   base;
  logic         pop;
  logic         push;
  logic         out_idle_w;

  // Overwrite eight byte slots starting at byte index slot with word.
  function automatic logic [127:0] place_word(input logic [127:0] buf_in,
                                              input logic [4:0]   slot,
                                              input logic [63:0]  word);
    logic [7:0]   sh;
    logic [127:0] mask;
    logic [127:0] data;
    sh   = {slot, 3'b000};
    mask = {64'h0, {64{1'b1}}} << sh;
    data = {64'h0, word} << sh;
    return (buf_in & ~mask) | data;
  endfunction

  assign out_idle_w        = (fill_p0 <= 5'd8);
  assign pop               = bus.in_enable & bus.in_idle & (fill_p0 >= 5'd5);
  assign push              = bus.in_enable & bus.in_datavalid & out_idle_w;
  assign bus.out_idle      = out_idle_w;
  assign bus.out_datavalid = pop;
  assign bus.out_data      = data_p0[39:0];
  assign bus.empty_save    = (fill_p0 == 5'd0);

  // Pop happens first, so a simultaneous push lands right behind the surviving bytes.
  always_comb begin
    shifted  = data_p0;
    base     = fill_p0;
    data_nxt = data_p0;
    fill_nxt = fill_p0;
    if (pop) begin
      shifted = data_p0 >> 40;
      base    = fill_p0 - 5'd5;
    end
    if (push) begin
      data_nxt = place_word(shifted, base, bus.in_data);
      fill_nxt = base + 5'd8;
    end else if (pop) begin
      data_nxt = shifted;
      fill_nxt = base;
    end
  end

  // Buffer/fill register stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_p0 <= '0;
      fill_p0 <= '0;
    end else begin
      data_p0 <= data_nxt;
      fill_p0 <= fill_nxt;
    end
  end

`ifdef GEARBOX_64_40_STATUS_EN
  logic ovf_p0;

  // Sticky: any offered word the full buffer had to drop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_p0 <= 1'b0;
    end else if (bus.in_enable & bus.in_datavalid & ~out_idle_w) begin
      ovf_p0 <= 1'b1;
    end
  end

  assign fill_level = fill_p0;
  assign overflow   = ovf_p0;
`endif

endmodule
